// File: rtl/reg_bank_16x32_writer.sv
// reg_bank_16x32_writer: 16x32 register bank write side with valid/ready writes and a one-entry-per-cycle clear sequencer.
module reg_bank_16x32_writer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [3:0]            i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_clr_req,
    output logic                  o_busy,
    output logic                  o_clr_done,
    output logic [15:0]           o_wr_strobe,
    output logic [DATA_WIDTH-1:0] o_q0,
    output logic [DATA_WIDTH-1:0] o_q1,
    output logic [DATA_WIDTH-1:0] o_q2,
    output logic [DATA_WIDTH-1:0] o_q3,
    output logic [DATA_WIDTH-1:0] o_q4,
    output logic [DATA_WIDTH-1:0] o_q5,
    output logic [DATA_WIDTH-1:0] o_q6,
    output logic [DATA_WIDTH-1:0] o_q7,
    output logic [DATA_WIDTH-1:0] o_q8,
    output logic [DATA_WIDTH-1:0] o_q9,
    output logic [DATA_WIDTH-1:0] o_q10,
    output logic [DATA_WIDTH-1:0] o_q11,
    output logic [DATA_WIDTH-1:0] o_q12,
    output logic [DATA_WIDTH-1:0] o_q13,
    output logic [DATA_WIDTH-1:0] o_q14,
    output logic [DATA_WIDTH-1:0] o_q15
);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]            r_state;
    logic [3:0]            r_cnt;
    logic                  r_clr_done;
    logic [15:0]           r_strobe;
    logic                  w_accept;
    logic                  w_clr_en;
    logic [DATA_WIDTH-1:0] w_q [16];

    assign o_wr_ready  = (r_state == S_IDLE) & ~i_clr_req;
    assign w_accept    = i_wr_valid & o_wr_ready;
    assign w_clr_en    = (r_state == S_CLEAR);
    assign o_busy      = w_clr_en;
    assign o_clr_done  = r_clr_done;
    assign o_wr_strobe = r_strobe;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_clr_done <= 1'b0;
            r_strobe   <= 16'd0;
        end else begin
            r_strobe   <= w_accept ? (16'd1 << i_wr_addr) : 16'd0;
            r_clr_done <= w_clr_en && (r_cnt == 4'd15);
            if (r_state == S_IDLE) begin
                if (i_clr_req) begin
                    r_state <= S_CLEAR;
                    r_cnt   <= 4'd0;
                end
            end else begin
                r_cnt <= r_cnt + 4'd1;
                if (r_cnt == 4'd15)
                    r_state <= S_IDLE;
            end
        end
    end

    // Clear and write never coincide: writes are only accepted in IDLE.
    for (genvar k = 0; k < 16; k++) begin : g_ent
        logic [DATA_WIDTH-1:0] r_q;
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n)
                r_q <= '0;
            else if (w_clr_en && (r_cnt == 4'(k)))
                r_q <= '0;
            else if (w_accept && (i_wr_addr == 4'(k)))
                r_q <= i_wr_data;
        end
        assign w_q[k] = r_q;
    end

    assign o_q0  = w_q[0];
    assign o_q1  = w_q[1];
    assign o_q2  = w_q[2];
    assign o_q3  = w_q[3];
    assign o_q4  = w_q[4];
    assign o_q5  = w_q[5];
    assign o_q6  = w_q[6];
    assign o_q7  = w_q[7];
    assign o_q8  = w_q[8];
    assign o_q9  = w_q[9];
    assign o_q10 = w_q[10];
    assign o_q11 = w_q[11];
    assign o_q12 = w_q[12];
    assign o_q13 = w_q[13];
    assign o_q14 = w_q[14];
    assign o_q15 = w_q[15];
endmodule

// File: doc/reg_bank_16x32_writer.md
# reg_bank_16x32_writer

Write side of the 16-entry, 32-bit register bank whose read side is the 16-to-1 select mux. It accepts single-word writes over a valid/ready handshake, decodes a 4-bit address into one of 16 registers, and exposes all 16 register values as parallel outputs that feed the mux data inputs. A built-in clear sequencer zeroes the bank one entry per cycle on request.

## Interface
- DATA_WIDTH, 32, width of each register and of wr_data/q outputs
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- wr_valid  in  1  write request
- wr_ready  out  1  block can accept a write this cycle
- wr_addr  in  4  target register index 0..15
- wr_data  in  DATA_WIDTH  write data
- clr_req  in  1  request a full-bank clear
- busy  out  1  clear sequence in progress
- clr_done  out  1  one-cycle pulse, clear sequence finished
- wr_strobe  out  16  one-hot, registered: bit k high one cycle after register k accepted a write
- q0..q15  out  DATA_WIDTH each  current register contents, q0 = entry 0 … q15 = entry 15

## Operation
- One clock; reset is asynchronous and active-low: reset_n low forces, immediately and regardless of clk, all q* = 0, state = IDLE, clear counter = 0, busy = 0, clr_done = 0, wr_strobe = 0.
- FSM states: IDLE, CLEAR.
- IDLE: wr_ready = ~clr_req (combinational). A write is accepted on a rising edge where wr_valid & wr_ready; register[wr_addr] <= wr_data, all other registers hold.
- IDLE with clr_req = 1 at an edge: go to CLEAR, counter <= 0; a simultaneous wr_valid is NOT accepted (wr_ready was 0); the writer must hold the request.
- CLEAR: wr_ready = 0, busy = 1. Each edge: register[counter] <= 0, counter <= counter + 1. On the edge where counter = 15, entry 15 is cleared, counter wraps to 0, state <= IDLE, clr_done <= 1.
- clr_req while in CLEAR is ignored (no restart, no extension).
- wr_valid while in CLEAR is held off by wr_ready = 0; no register changes except the clear target.
- wr_strobe: on each accepting edge, wr_strobe <= one-hot(wr_addr); otherwise wr_strobe <= 0. Clear steps never assert wr_strobe.
- clr_done is high for exactly one cycle, otherwise 0.
- Back-to-back writes to any addresses, including the same address, are accepted every cycle in IDLE; last write wins.
- wr_addr is fully decoded: every value 0..15 maps to exactly one register, no aliasing, no unused codes.

## Timing
- Write latency: data presented at edge T is visible on q[wr_addr] after edge T (same cycle as wr_strobe).
- Clear: clr_req sampled high at edge T0 -> busy high from T0 to T16; entry k cleared at edge T(k+1); IDLE and clr_done high from T16 to T17; wr_ready may be high from T16 onward.
- Total clear duration 16 cycles, fixed.
- Reset asserted mid-clear or mid-write aborts immediately; after release the block is in IDLE with all entries 0.
- All outputs except wr_ready are registered; wr_ready depends combinationally on state and clr_req only (never on wr_valid).

## Test plan
- Reset: drive reset_n low between edges -> all q* = 0, wr_ready = 1, busy = 0, clr_done = 0, wr_strobe = 0 without waiting for an edge.
- Address decode sweep: write 0xA5A5_0000 + k to address k, k = 0..15 on consecutive cycles -> q_k = 0xA5A5_000k, wr_strobe = 1<<k one cycle after each write, no other entry disturbed.
- Same-address back-to-back: write 0x1111_1111 then 0x2222_2222 to address 3 -> q3 = 0x2222_2222, wr_strobe = 0x0008 for two consecutive cycles.
- Clear sequence: fill all entries with 0xFFFF_FFFF, pulse clr_req one cycle -> busy high 16 cycles, entry k reads 0 from edge T(k+1), clr_done one pulse at end, all q* = 0.
- Collision: assert clr_req and wr_valid (addr 7, data 0xDEAD_BEEF) together in IDLE, hold wr_valid -> wr_ready = 0, write not taken during clear, accepted on first IDLE cycle after clr_done; final q7 = 0xDEAD_BEEF.
- Reset mid-clear: assert reset_n low at clear step 8 -> all q* = 0, busy = 0 immediately; after release a new write to address 15 is accepted normally.
